// File: rtl/digit_serial_addsub_pkg.sv
// rtl/digit_serial_addsub_pkg.sv - shared FSM encodings and parameter legality check
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit legal_params(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_digit_adder.sv
// rtl/ripple_digit_adder.sv - combinational DIGIT-bit ripple adder with carry into MSB exposed
module ripple_digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[DIGIT];
  // carry into the top bit; on the final digit this feeds signed overflow
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - digit-serial two's-complement add/sub with start/done handshake
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVR,
  output logic             Z
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!legal_params(WIDTH, DIGIT)) begin : g_param_check
    $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] work, work_nxt;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;
  logic             accept, last;

  ripple_digit_adder #(.DIGIT(DIGIT)) u_adder (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  // sum digits enter at the MSB end so the LSB digit lands in place after N shifts
  if (N == 1) begin : g_single
    assign work_nxt = dsum;
  end else begin : g_multi
    assign work_nxt = {dsum, work[WIDTH-1:DIGIT]};
  end

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(N - 1));
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      OVR   <= 1'b0;
      Z     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= B ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
      end else if (state == BUSY) begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        carry <= dcout;
        cnt   <= cnt + 1'b1;
        work  <= work_nxt;
        if (last) begin
          S    <= work_nxt;
          Cout <= dcout;
          OVR  <= dcmsb ^ dcout;
          Z    <= (work_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - self-checking bench for digit_serial_addsub (16/4 and 8/8)
module tb_digit_serial_addsub;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start16, sub16, busy16, done16, cout16, ovr16, z16;
  logic [15:0] a16, b16, s16;
  logic        start8, sub8, busy8, done8, cout8, ovr8, z8;
  logic [7:0]  a8, b8, s8;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .S(s16), .Cout(cout16), .OVR(ovr16), .Z(z16)
  );

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .OVR(ovr8), .Z(z8)
  );

  exp_t sb16[$];
  exp_t sb8[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // arithmetic reference: full-width sum for Cout, sum of the low w-1 bits for carry into MSB
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    logic [31:0] mask, hmask, aa, bb, full, low;
    exp_t e;
    mask  = (32'd1 << w) - 1;
    hmask = (32'd1 << (w - 1)) - 1;
    aa    = {16'd0, a} & mask;
    bb    = (s ? ~{16'd0, b} : {16'd0, b}) & mask;
    full  = aa + bb + {31'd0, s};
    low   = (aa & hmask) + (bb & hmask) + {31'd0, s};
    e.s   = full[15:0] & mask[15:0];
    e.c   = full[w];
    e.o   = low[w-1] ^ full[w];
    e.z   = (e.s == 16'd0);
    return e;
  endfunction

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      if (sb16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done16 actual=1 required=0 at %0t", $time);
      end else begin
        e = sb16.pop_front();
        chk("s16", 32'(s16), 32'(e.s));
        chk("cout16", 32'(cout16), 32'(e.c));
        chk("ovr16", 32'(ovr16), 32'(e.o));
        chk("z16", 32'(z16), 32'(e.z));
        chk("busy16_at_done", 32'(busy16), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (sb8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8 actual=1 required=0 at %0t", $time);
      end else begin
        e = sb8.pop_front();
        chk("s8", 32'(s8), 32'(e.s));
        chk("cout8", 32'(cout8), 32'(e.c));
        chk("ovr8", 32'(ovr8), 32'(e.o));
        chk("z8", 32'(z8), 32'(e.z));
      end
    end
  end

  // called at a falling edge (cycle 0); returns at the falling edge of cycle 1
  task automatic start_op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                            input exp_t e, input bit push);
    a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
    if (push) sb16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input exp_t e);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    sb8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done16(input int c0, output int cyc);
    cyc = c0;
    while (!done16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done8(input int c0, output int cyc);
    cyc = c0;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t        tbl[8];
  int          cyc;
  logic [15:0] prev_s;
  logic [7:0]  ra, rb;
  logic        rs;

  initial begin
    tbl[0] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[1] = '{16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[4] = '{16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{16'h5555, 16'h5555, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};
    tbl[7] = '{16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};

    reset = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_s", 32'(s16), 32'd0);
    chk("rst_cout", 32'(cout16), 32'd0);
    chk("rst_ovr", 32'(ovr16), 32'd0);
    chk("rst_z", 32'(z16), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    prev_s = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      start_op16(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, 1'b1);
      chk("busy_cycle1", 32'(busy16), 32'd1);
      chk("hold_s_during_busy", 32'(s16), 32'(prev_s));
      wait_done16(1, cyc);
      chk("latency16", 32'(cyc), 32'd5);
      prev_s = tbl[i].e.s;
      @(negedge clk);
    end

    // second op issued by holding start in the DONE cycle
    start_op16(16'hFFFF, 16'h0001, 1'b0, model(16, 16'hFFFF, 16'h0001, 1'b0), 1'b1);
    wait_done16(1, cyc);
    chk("b2b_latency_first", 32'(cyc), 32'd5);
    start_op16(16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_done16(1, cyc);
    chk("b2b_latency_second", 32'(cyc), 32'd5);
    @(negedge clk);

    // start pulses during BUSY with different operands must be ignored
    start_op16(16'h0F0F, 16'h0101, 1'b0, model(16, 16'h0F0F, 16'h0101, 1'b0), 1'b1);
    @(negedge clk);
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1;
    @(negedge clk);
    a16 = 16'h0001; b16 = 16'h7000; sub16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(4, cyc);
    chk("ignored_start_latency", 32'(cyc), 32'd5);
    repeat (3) @(negedge clk);
    chk("idle_after_ignored", 32'(busy16), 32'd0);

    // reset in the middle of BUSY aborts the op
    start_op16(16'h1111, 16'h2222, 1'b0, model(16, 16'h1111, 16'h2222, 1'b0), 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_done", 32'(done16), 32'd0);
    chk("abort_s", 32'(s16), 32'd0);
    chk("abort_z", 32'(z16), 32'd1);
    chk("abort_cout", 32'(cout16), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // single-cycle configuration
    start_op8(8'h7F, 8'h01, 1'b0, '{16'h0080, 1'b0, 1'b1, 1'b0});
    wait_done8(1, cyc);
    chk("latency8", 32'(cyc), 32'd2);
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      start_op8(ra, rb, rs, model(8, {8'd0, ra}, {8'd0, rb}, rs));
      wait_done8(1, cyc);
      if (cyc != 2) chk("latency8_rand", 32'(cyc), 32'd2);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    chk("sb16_drained", 32'(sb16.size()), 32'd0);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
